// File: rtl/morra_scoreboard_if.sv
// Morra scoreboard bus: game-FSM inputs plus display/tally outputs.
// master drives the game side, slave is the scoreboard.
interface morra_scoreboard_if #(
  parameter int RND_W  = 4,
  parameter int GAME_W = 8
);
  logic              START;
  logic [1:0]        ROUND;
  logic [1:0]        GAME;
  logic [RND_W-1:0]  P1_ROUNDS;
  logic [RND_W-1:0]  P2_ROUNDS;
  logic [RND_W-1:0]  DRAWS;
  logic [RND_W-1:0]  NULLS;
  logic [GAME_W-1:0] P1_GAMES;
  logic [GAME_W-1:0] P2_GAMES;
  logic [GAME_W-1:0] TIED_GAMES;
  logic [1:0]        LAST_GAME;
  logic [1:0]        LEADER;
  logic              BUSY;
  logic              GAME_DONE;
  logic              ERR;

  modport master (
    output START, ROUND, GAME,
    input  P1_ROUNDS, P2_ROUNDS, DRAWS, NULLS,
    input  P1_GAMES, P2_GAMES, TIED_GAMES,
    input  LAST_GAME, LEADER, BUSY, GAME_DONE, ERR
  );

  modport slave (
    input  START, ROUND, GAME,
    output P1_ROUNDS, P2_ROUNDS, DRAWS, NULLS,
    output P1_GAMES, P2_GAMES, TIED_GAMES,
    output LAST_GAME, LEADER, BUSY, GAME_DONE, ERR
  );
endinterface

// File: rtl/morra_scoreboard.sv
// Morra scoreboard: per-game round tallies, match game tallies,
// leader and sticky protocol-error flag. Observer of the game FSM.
module morra_scoreboard #(
  parameter int RND_W  = 4,
  parameter int GAME_W = 8
) (
  input  logic               clk,
  input  logic               RST,
  morra_scoreboard_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_PLAY = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [RND_W-1:0]  p1r_q, p1r_d;
  logic [RND_W-1:0]  p2r_q, p2r_d;
  logic [RND_W-1:0]  drw_q, drw_d;
  logic [RND_W-1:0]  nul_q, nul_d;
  logic [GAME_W-1:0] p1g_q, p1g_d;
  logic [GAME_W-1:0] p2g_q, p2g_d;
  logic [GAME_W-1:0] tig_q, tig_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        lead_q, lead_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       start;
  logic [1:0] round;
  logic [1:0] game;

  assign start = bus.START;
  assign round = bus.ROUND;
  assign game  = bus.GAME;

  function automatic logic [RND_W-1:0] inc_r(
    input logic [RND_W-1:0] v
  );
    return (&v) ? v : v + RND_W'(1);
  endfunction

  function automatic logic [GAME_W-1:0] inc_g(
    input logic [GAME_W-1:0] v
  );
    return (&v) ? v : v + GAME_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    p1r_d   = p1r_q;
    p2r_d   = p2r_q;
    drw_d   = drw_q;
    nul_d   = nul_q;
    p1g_d   = p1g_q;
    p2g_d   = p2g_q;
    tig_d   = tig_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          p1r_d   = '0;
          p2r_d   = '0;
          drw_d   = '0;
          nul_d   = '0;
        end else if (round != 2'b00 || game != 2'b00) begin
          err_d = 1'b1;
        end
      end
      S_ARM: begin
        if (start) begin
          p1r_d = '0;
          p2r_d = '0;
          drw_d = '0;
          nul_d = '0;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (start) begin
          state_d = S_ARM;
          p1r_d   = '0;
          p2r_d   = '0;
          drw_d   = '0;
          nul_d   = '0;
        end else begin
          unique case (round)
            2'b01:   p1r_d = inc_r(p1r_q);
            2'b10:   p2r_d = inc_r(p2r_q);
            2'b11:   drw_d = inc_r(drw_q);
            default: nul_d = inc_r(nul_q);
          endcase
          if (game != 2'b00) begin
            state_d = S_IDLE;
          end
        end
        // A game result is tallied whether or not START cuts in.
        if (game != 2'b00) begin
          last_d = game;
          done_d = 1'b1;
          unique case (game)
            2'b01:   p1g_d = inc_g(p1g_q);
            2'b10:   p2g_d = inc_g(p2g_q);
            default: tig_d = inc_g(tig_q);
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    if (last_d == 2'b00) begin
      lead_d = 2'b00;
    end else if (p1g_d > p2g_d) begin
      lead_d = 2'b01;
    end else if (p2g_d > p1g_d) begin
      lead_d = 2'b10;
    end else begin
      lead_d = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      p1r_q   <= '0;
      p2r_q   <= '0;
      drw_q   <= '0;
      nul_q   <= '0;
      p1g_q   <= '0;
      p2g_q   <= '0;
      tig_q   <= '0;
      last_q  <= 2'b00;
      lead_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p1r_q   <= p1r_d;
      p2r_q   <= p2r_d;
      drw_q   <= drw_d;
      nul_q   <= nul_d;
      p1g_q   <= p1g_d;
      p2g_q   <= p2g_d;
      tig_q   <= tig_d;
      last_q  <= last_d;
      lead_q  <= lead_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.P1_ROUNDS  = p1r_q;
  assign bus.P2_ROUNDS  = p2r_q;
  assign bus.DRAWS      = drw_q;
  assign bus.NULLS      = nul_q;
  assign bus.P1_GAMES   = p1g_q;
  assign bus.P2_GAMES   = p2g_q;
  assign bus.TIED_GAMES = tig_q;
  assign bus.LAST_GAME  = last_q;
  assign bus.LEADER     = lead_q;
  assign bus.BUSY       = busy_q;
  assign bus.GAME_DONE  = done_q;
  assign bus.ERR        = err_q;

endmodule

// File: tb/tb_morra_scoreboard.sv
// Testbench for morra_scoreboard: directed scenarios plus
// random play checked against a behavioural model.
module tb_morra_scoreboard;

  localparam int RND_W  = 4;
  localparam int GAME_W = 8;
  localparam int RMAX   = (1 << RND_W) - 1;
  localparam int GMAX   = (1 << GAME_W) - 1;

  logic clk;
  logic RST;

  morra_scoreboard_if #(.RND_W(RND_W), .GAME_W(GAME_W)) bus ();

  morra_scoreboard #(.RND_W(RND_W), .GAME_W(GAME_W)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // model: rounds indexed by ROUND code (0 null,1 p1,2 p2,3 draw)
  int m_phase;
  int m_rounds[4];
  int m_games[4];
  int m_last;
  int m_done;
  int m_err;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic m_clear_rounds();
    for (int i = 0; i < 4; i++) m_rounds[i] = 0;
  endtask

  task automatic m_tally_game(input int g);
    m_games[g] = sat(m_games[g], GMAX);
    m_last = g;
    m_done = 1;
  endtask

  task automatic m_step(input int r, input int st, input int rd, input int gm);
    m_done = 0;
    if (r != 0) begin
      m_phase = 0;
      m_clear_rounds();
      for (int i = 0; i < 4; i++) m_games[i] = 0;
      m_last = 0;
      m_err = 0;
    end else if (m_phase == 0) begin
      if (st != 0) begin
        m_clear_rounds();
        m_phase = 1;
      end else if (rd != 0 || gm != 0) begin
        m_err = 1;
      end
    end else if (m_phase == 1) begin
      if (st != 0) m_clear_rounds();
      else m_phase = 2;
    end else begin
      if (st != 0) begin
        if (gm != 0) m_tally_game(gm);
        m_clear_rounds();
        m_phase = 1;
      end else begin
        m_rounds[rd] = sat(m_rounds[rd], RMAX);
        if (gm != 0) begin
          m_tally_game(gm);
          m_phase = 0;
        end
      end
    end
  endtask

  function automatic int m_leader();
    if (m_last == 0) return 0;
    if (m_games[1] > m_games[2]) return 1;
    if (m_games[2] > m_games[1]) return 2;
    return 3;
  endfunction

  task automatic check_model();
    check("p1_rounds", int'(bus.P1_ROUNDS), m_rounds[1]);
    check("p2_rounds", int'(bus.P2_ROUNDS), m_rounds[2]);
    check("draws", int'(bus.DRAWS), m_rounds[3]);
    check("nulls", int'(bus.NULLS), m_rounds[0]);
    check("p1_games", int'(bus.P1_GAMES), m_games[1]);
    check("p2_games", int'(bus.P2_GAMES), m_games[2]);
    check("tied_games", int'(bus.TIED_GAMES), m_games[3]);
    check("last_game", int'(bus.LAST_GAME), m_last);
    check("leader", int'(bus.LEADER), m_leader());
    check("busy", int'(bus.BUSY), int'(m_phase != 0));
    check("game_done", int'(bus.GAME_DONE), m_done);
    check("err", int'(bus.ERR), m_err);
  endtask

  task automatic cyc(input int r, input int st, input int rd, input int gm);
    @(negedge clk);
    RST       = (r != 0);
    bus.START = (st != 0);
    bus.ROUND = 2'(rd);
    bus.GAME  = 2'(gm);
    @(posedge clk);
    #1;
    m_step(r, st, rd, gm);
    check_model();
  endtask

  int saved;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    m_phase = 0;
    m_last = 0;
    m_done = 0;
    m_err = 0;
    RST = 1'b1;
    bus.START = 1'b0;
    bus.ROUND = 2'b00;
    bus.GAME  = 2'b00;

    // T1 reset
    cyc(1, 0, 0, 0);
    check("t1_leader", int'(bus.LEADER), 0);
    check("t1_busy", int'(bus.BUSY), 0);
    check("t1_err", int'(bus.ERR), 0);

    // T2 full game won by P1
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 2, 0);
    cyc(0, 0, 3, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    check("t2_p1r", int'(bus.P1_ROUNDS), 3);
    check("t2_p2r", int'(bus.P2_ROUNDS), 1);
    check("t2_draws", int'(bus.DRAWS), 1);
    check("t2_nulls", int'(bus.NULLS), 1);
    check("t2_p1g", int'(bus.P1_GAMES), 1);
    check("t2_last", int'(bus.LAST_GAME), 1);
    check("t2_leader", int'(bus.LEADER), 1);
    check("t2_done", int'(bus.GAME_DONE), 1);
    check("t2_busy", int'(bus.BUSY), 0);
    cyc(0, 0, 0, 0);
    check("t2_done_pulse", int'(bus.GAME_DONE), 0);
    check("t2_hold_p1r", int'(bus.P1_ROUNDS), 3);

    // T3 abort by START mid-game
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 2, 0);
    cyc(0, 0, 2, 0);
    check("t3_p2r_mid", int'(bus.P2_ROUNDS), 2);
    cyc(0, 1, 0, 0);
    check("t3_p2r", int'(bus.P2_ROUNDS), 0);
    check("t3_busy", int'(bus.BUSY), 1);
    check("t3_p1g", int'(bus.P1_GAMES), 1);
    check("t3_p2g", int'(bus.P2_GAMES), 0);
    check("t3_done", int'(bus.GAME_DONE), 0);

    // T4 null saturation
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    check("t4_nulls", int'(bus.NULLS), 15);
    check("t4_err", int'(bus.ERR), 0);
    cyc(0, 0, 0, 3);

    // T5 IDLE violation is sticky
    saved = int'(bus.P2_ROUNDS);
    cyc(0, 0, 2, 0);
    check("t5_err", int'(bus.ERR), 1);
    check("t5_p2r", int'(bus.P2_ROUNDS), saved);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 2);
    check("t5_err_hold", int'(bus.ERR), 1);
    cyc(1, 0, 0, 0);
    check("t5_err_rst", int'(bus.ERR), 0);

    // T6 P1 win, P2 win, tie
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 2, 2);
    check("t6_leader_mid", int'(bus.LEADER), 3);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 3, 3);
    check("t6_p1g", int'(bus.P1_GAMES), 1);
    check("t6_p2g", int'(bus.P2_GAMES), 1);
    check("t6_tie", int'(bus.TIED_GAMES), 1);
    check("t6_leader", int'(bus.LEADER), 3);
    check("t6_last", int'(bus.LAST_GAME), 3);

    // START with a result on the same edge tallies and re-arms
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 2);
    check("st_gm_p2g", int'(bus.P2_GAMES), 2);
    check("st_gm_p1r", int'(bus.P1_ROUNDS), 0);
    check("st_gm_done", int'(bus.GAME_DONE), 1);

    // random play, mostly in games, with occasional reset
    for (int i = 0; i < 4000; i++) begin
      int r, st, rd, gm;
      r  = ($urandom_range(0, 299) == 0) ? 1 : 0;
      st = ($urandom_range(0, 11) == 0) ? 1 : 0;
      rd = $urandom_range(0, 3);
      gm = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      if (m_phase == 0 && $urandom_range(0, 3) != 0) begin
        rd = 0;
        gm = 0;
      end
      cyc(r, st, rd, gm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
